gate_ctrl_param: RTL and testbench

Parametrised parking-gate controller. It is the next-generation device driven by the team's gate stimulus bench (sensorA/sensorB/pass → gateState/blockAlarm/wrongPinAlarm). Additions over the first generation:
- configurable PIN width and value
- configurable retry limit
- explicit PIN-entry strobe
- gate-open timeout
- remaining-tries output
It sits between the vehicle sensors/keypad and the gate actuator and alarm panel.

---
 rtl/gate_pkg.sv | 25 ++
 rtl/gate_pin_checker.sv | 58 +++++
 rtl/gate_ctrl_param.sv | 127 ++++++++++++
 tb/tb_gate_ctrl_param.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and sizing helpers for the parametrised parking-gate controller.
package gate_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PIN  = 2'd1,
    GATE_OPEN = 2'd2,
    BLOCKED   = 2'd3
  } gate_state_t;

  localparam int unsigned DEFAULT_PIN_W        = 8;
  localparam logic [7:0]  DEFAULT_PIN          = 8'b00100110;
  localparam int unsigned DEFAULT_MAX_TRIES    = 3;
  localparam int unsigned DEFAULT_OPEN_TIMEOUT = 50;

  // Tries counter must hold 0..max_tries inclusive.
  function automatic int unsigned tries_w(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

  function automatic int unsigned timeout_w(input int unsigned open_timeout);
    return (open_timeout < 2) ? 1 : $clog2(open_timeout);
  endfunction

endpackage

// File: rtl/gate_pin_checker.sv
// PIN comparison, saturating wrong-entry counter, lockout alarm and remaining-tries output.
module gate_pin_checker
  import gate_pkg::*;
#(
  parameter int unsigned          PIN_W     = DEFAULT_PIN_W,
  parameter logic [PIN_W-1:0]     PIN_VALUE = PIN_W'(DEFAULT_PIN),
  parameter int unsigned          MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIN_W-1:0]              pass,
  input  logic                          pass_valid,
  input  logic                          clear,
  input  logic                          count,
  output logic                          match,
  output logic                          wrong,
  output logic                          wrong_alarm,
  output logic [tries_w(MAX_TRIES)-1:0] tries_left
);

  localparam int unsigned          TRIES_W   = tries_w(MAX_TRIES);
  localparam logic [TRIES_W-1:0]   TRIES_MAX = TRIES_W'(MAX_TRIES);

  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               alarm_q, alarm_d;

  assign match = pass_valid && (pass == PIN_VALUE);
  assign wrong = pass_valid && (pass != PIN_VALUE);

  always_comb begin
    tries_d = tries_q;
    alarm_d = alarm_q;
    if (clear) begin
      tries_d = '0;
      alarm_d = 1'b0;
    end else if (count) begin
      tries_d = (tries_q == TRIES_MAX) ? TRIES_MAX : tries_q + 1'b1;
      if (tries_d == TRIES_MAX) begin
        alarm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tries_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      tries_q <= tries_d;
      alarm_q <= alarm_d;
    end
  end

  assign wrong_alarm = alarm_q;
  // Counter saturates at TRIES_MAX, so this subtraction cannot wrap.
  assign tries_left  = TRIES_MAX - tries_q;

endmodule

// File: rtl/gate_ctrl_param.sv
// Parking-gate controller: entry FSM, open-gate timeout and tailgating detection around a PIN checker.
module gate_ctrl_param
  import gate_pkg::*;
#(
  parameter int unsigned      PIN_W        = DEFAULT_PIN_W,
  parameter logic [PIN_W-1:0] PIN_VALUE    = PIN_W'(DEFAULT_PIN),
  parameter int unsigned      MAX_TRIES    = DEFAULT_MAX_TRIES,
  parameter int unsigned      OPEN_TIMEOUT = DEFAULT_OPEN_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sensorA,
  input  logic                          sensorB,
  input  logic [PIN_W-1:0]              pass,
  input  logic                          pass_valid,
  output logic                          gateState,
  output logic                          blockAlarm,
  output logic                          wrongPinAlarm,
  output logic [tries_w(MAX_TRIES)-1:0] tries_left
);

  localparam int unsigned      TO_W    = timeout_w(OPEN_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(OPEN_TIMEOUT - 1);

  gate_state_t      state_q, state_d;
  logic             gate_q, gate_d;
  logic             block_q, block_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             pin_clear, pin_count;
  logic             match, wrong;

  gate_pin_checker #(
    .PIN_W     (PIN_W),
    .PIN_VALUE (PIN_VALUE),
    .MAX_TRIES (MAX_TRIES)
  ) u_pin (
    .clk         (clk),
    .reset       (reset),
    .pass        (pass),
    .pass_valid  (pass_valid),
    .clear       (pin_clear),
    .count       (pin_count),
    .match       (match),
    .wrong       (wrong),
    .wrong_alarm (wrongPinAlarm),
    .tries_left  (tries_left)
  );

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    block_d   = block_q;
    to_d      = to_q;
    pin_clear = 1'b0;
    pin_count = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d  = 1'b0;
        block_d = 1'b0;
        if (sensorA) begin
          state_d = WAIT_PIN;
        end
      end
      WAIT_PIN: begin
        if (match) begin
          state_d   = GATE_OPEN;
          gate_d    = 1'b1;
          to_d      = '0;
          pin_clear = 1'b1;
        end else if (wrong) begin
          pin_count = 1'b1;
        end else if (!sensorA) begin
          state_d = IDLE;
        end
      end
      GATE_OPEN: begin
        to_d = to_q + 1'b1;
        // Tailgating outranks a normal close; both outrank the timeout.
        if (sensorA && sensorB) begin
          state_d = BLOCKED;
          gate_d  = 1'b0;
          block_d = 1'b1;
        end else if (sensorB) begin
          state_d = IDLE;
          gate_d  = 1'b0;
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
          gate_d  = 1'b0;
        end
      end
      BLOCKED: begin
        gate_d = 1'b0;
        if (match) begin
          state_d = IDLE;
          block_d = 1'b0;
        end else if (wrong) begin
          pin_count = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        gate_d    = 1'b0;
        block_d   = 1'b0;
        to_d      = '0;
        pin_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gate_q  <= 1'b0;
      block_q <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      block_q <= block_d;
      to_q    <= to_d;
    end
  end

  assign gateState  = gate_q;
  assign blockAlarm = block_q;

endmodule

// File: tb/tb_gate_ctrl_param.sv
// Directed bench for gate_ctrl_param: default instance plus a 4-bit PIN / single-try instance.
module tb_gate_ctrl_param;

  logic       clk;
  logic       reset;

  logic       a_sa, a_sb, a_pv;
  logic [7:0] a_pass;
  logic       a_gate, a_block, a_wpa;
  logic [1:0] a_left;

  logic       b_sa, b_sb, b_pv;
  logic [3:0] b_pass;
  logic       b_gate, b_block, b_wpa;
  logic [0:0] b_left;

  logic [4:0] ao;
  logic [3:0] bo;

  int checks = 0;
  int errors = 0;

  assign ao = {a_gate, a_block, a_wpa, a_left};
  assign bo = {b_gate, b_block, b_wpa, b_left};

  gate_ctrl_param #(
    .PIN_W        (8),
    .PIN_VALUE    (8'b00100110),
    .MAX_TRIES    (3),
    .OPEN_TIMEOUT (50)
  ) u_a (
    .clk           (clk),
    .reset         (reset),
    .sensorA       (a_sa),
    .sensorB       (a_sb),
    .pass          (a_pass),
    .pass_valid    (a_pv),
    .gateState     (a_gate),
    .blockAlarm    (a_block),
    .wrongPinAlarm (a_wpa),
    .tries_left    (a_left)
  );

  gate_ctrl_param #(
    .PIN_W     (4),
    .PIN_VALUE (4'hA),
    .MAX_TRIES (1)
  ) u_b (
    .clk           (clk),
    .reset         (reset),
    .sensorA       (b_sa),
    .sensorB       (b_sb),
    .pass          (b_pass),
    .pass_valid    (b_pv),
    .gateState     (b_gate),
    .blockAlarm    (b_block),
    .wrongPinAlarm (b_wpa),
    .tries_left    (b_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic strobe_a(input logic [7:0] p);
    a_pass = p;
    a_pv   = 1'b1;
    cyc();
    a_pv   = 1'b0;
  endtask

  task automatic strobe_b(input logic [3:0] p);
    b_pass = p;
    b_pv   = 1'b1;
    cyc();
    b_pv   = 1'b0;
  endtask

  // Vector layout: {gate, block, wrongPinAlarm, tries_left}
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL reset_a: outputs=%b expected %b", ao, 5'b00011);
    end
    checks++;
    if (bo !== 4'b0001) begin
      errors++;
      $display("FAIL reset_b: outputs=%b expected %b", bo, 4'b0001);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_correct_entry();
    a_sa = 1'b1;
    cyc();
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL entry_wait: outputs=%b expected %b", ao, 5'b00011);
    end
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b10011) begin
      errors++;
      $display("FAIL entry_open: outputs=%b expected %b", ao, 5'b10011);
    end
    a_sa = 1'b0;
    a_sb = 1'b1;
    cyc();
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL entry_close: outputs=%b expected %b", ao, 5'b00011);
    end
    a_sb = 1'b0;
    cyc();
  endtask

  task automatic test_wrong_lockout();
    logic [4:0] exp;
    a_sa = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      strobe_a(8'h00);
      exp = {1'b0, 1'b0, (i == 2), 2'(2 - i)};
      checks++;
      if (ao !== exp) begin
        errors++;
        $display("FAIL lockout_wrong%0d: outputs=%b expected %b", i, ao, exp);
      end
    end
    strobe_a(8'h00);
    checks++;
    if (ao !== 5'b00100) begin
      errors++;
      $display("FAIL lockout_saturate: outputs=%b expected %b", ao, 5'b00100);
    end
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b10011) begin
      errors++;
      $display("FAIL lockout_recover: outputs=%b expected %b", ao, 5'b10011);
    end
    a_sa = 1'b0;
    a_sb = 1'b1;
    cyc();
    a_sb = 1'b0;
    cyc();
  endtask

  task automatic test_wait_exit();
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL idle_ignores_pin: outputs=%b expected %b", ao, 5'b00011);
    end
    a_sa = 1'b1;
    cyc();
    strobe_a(8'h01);
    checks++;
    if (ao !== 5'b00010) begin
      errors++;
      $display("FAIL exit_wrong: outputs=%b expected %b", ao, 5'b00010);
    end
    a_sa = 1'b0;
    cyc();
    cyc();
    checks++;
    if (ao !== 5'b00010) begin
      errors++;
      $display("FAIL exit_keeps_tries: outputs=%b expected %b", ao, 5'b00010);
    end
    a_sa = 1'b1;
    cyc();
    a_sa = 1'b0;
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b10011) begin
      errors++;
      $display("FAIL match_beats_leave: outputs=%b expected %b", ao, 5'b10011);
    end
    a_sb = 1'b1;
    cyc();
    a_sb = 1'b0;
    cyc();
  endtask

  task automatic test_tailgate();
    logic [1:0] toggles [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    a_sa = 1'b1;
    cyc();
    strobe_a(8'b00100110);
    a_sb = 1'b1;
    cyc();
    checks++;
    if (ao !== 5'b01011) begin
      errors++;
      $display("FAIL tailgate_block: outputs=%b expected %b", ao, 5'b01011);
    end
    for (int i = 0; i < 4; i++) begin
      {a_sa, a_sb} = toggles[i];
      cyc();
      checks++;
      if (ao !== 5'b01011) begin
        errors++;
        $display("FAIL tailgate_toggle%0d: outputs=%b expected %b", i, ao, 5'b01011);
      end
    end
    strobe_a(8'hFF);
    checks++;
    if (ao !== 5'b01010) begin
      errors++;
      $display("FAIL blocked_wrong: outputs=%b expected %b", ao, 5'b01010);
    end
    a_sa = 1'b0;
    a_sb = 1'b0;
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b00010) begin
      errors++;
      $display("FAIL blocked_release: outputs=%b expected %b", ao, 5'b00010);
    end
    a_sa = 1'b1;
    cyc();
    strobe_a(8'b00100110);
    checks++;
    if (ao !== 5'b10011) begin
      errors++;
      $display("FAIL release_to_idle: outputs=%b expected %b", ao, 5'b10011);
    end
    a_sa = 1'b0;
    a_sb = 1'b1;
    cyc();
    a_sb = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int open_cycles;
    a_sa = 1'b1;
    cyc();
    strobe_a(8'b00100110);
    a_sa = 1'b0;
    open_cycles = (a_gate === 1'b1) ? 1 : 0;
    for (int n = 0; n < 60; n++) begin
      if (n == 10) begin
        a_pass = 8'h00;
        a_pv   = 1'b1;
      end else begin
        a_pv = 1'b0;
      end
      cyc();
      if (a_gate === 1'b1) open_cycles++;
      else break;
    end
    a_pv = 1'b0;
    checks++;
    if (open_cycles != 50) begin
      errors++;
      $display("FAIL timeout_len: open cycles=%0d expected 50", open_cycles);
    end
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL timeout_closed: outputs=%b expected %b", ao, 5'b00011);
    end
  endtask

  task automatic test_async_reset();
    a_sa = 1'b1;
    cyc();
    strobe_a(8'b00100110);
    a_sb = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) strobe_a(8'h00);
    checks++;
    if (ao !== 5'b01100) begin
      errors++;
      $display("FAIL prereset_state: outputs=%b expected %b", ao, 5'b01100);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL async_reset: outputs=%b expected %b", ao, 5'b00011);
    end
    a_sa = 1'b0;
    a_sb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc();
    checks++;
    if (ao !== 5'b00011) begin
      errors++;
      $display("FAIL post_reset: outputs=%b expected %b", ao, 5'b00011);
    end
  endtask

  task automatic test_param_sweep();
    b_sa = 1'b1;
    cyc();
    strobe_b(4'h3);
    checks++;
    if (bo !== 4'b0010) begin
      errors++;
      $display("FAIL sweep_wrong: outputs=%b expected %b", bo, 4'b0010);
    end
    strobe_b(4'h0);
    checks++;
    if (bo !== 4'b0010) begin
      errors++;
      $display("FAIL sweep_saturate: outputs=%b expected %b", bo, 4'b0010);
    end
    strobe_b(4'hA);
    checks++;
    if (bo !== 4'b1001) begin
      errors++;
      $display("FAIL sweep_open: outputs=%b expected %b", bo, 4'b1001);
    end
    b_sa = 1'b0;
    b_sb = 1'b1;
    cyc();
    checks++;
    if (bo !== 4'b0001) begin
      errors++;
      $display("FAIL sweep_close: outputs=%b expected %b", bo, 4'b0001);
    end
    b_sb = 1'b0;
    cyc();
  endtask

  initial begin
    reset  = 1'b0;
    a_sa   = 1'b0;
    a_sb   = 1'b0;
    a_pv   = 1'b0;
    a_pass = '0;
    b_sa   = 1'b0;
    b_sb   = 1'b0;
    b_pv   = 1'b0;
    b_pass = '0;
    test_reset();
    test_correct_entry();
    test_wrong_lockout();
    test_wait_exit();
    test_tailgate();
    test_timeout();
    test_async_reset();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
